// File: rtl/timer_pkg.sv
// Shared types and default constants for the countdown timer controller.
package timer_pkg;

    localparam int          DEF_CNT_W    = 6;
    localparam logic [31:0] DEF_NUM_1HZ  = 32'd50_000_000;
    localparam logic [31:0] DEF_NUM_FAST = 32'd5_000_000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector with an optional extra flop ahead of it for inputs
// that are asynchronous to clk (SYNC=1 gives a two-flop synchronizer).
module edge_det #(
    parameter bit SYNC = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_in,
    output logic o_pulse
);

    logic stage_in_s;
    logic cur_d;
    logic cur_q;
    logic prev_d;
    logic prev_q;

    generate
        if (SYNC) begin : g_sync
            logic meta_q;
            // First synchronizer flop for the asynchronous input.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    meta_q <= 1'b0;
                end else begin
                    meta_q <= i_in;
                end
            end
            assign stage_in_s = meta_q;
        end else begin : g_nosync
            assign stage_in_s = i_in;
        end
    endgenerate

    // Next values of the current and previous samples.
    always_comb begin
        cur_d  = stage_in_s;
        prev_d = cur_q;
    end

    // Sample registers feeding the edge detector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            cur_q  <= cur_d;
            prev_q <= prev_d;
        end
    end

    assign o_pulse = cur_q & ~prev_q;

endmodule

// File: rtl/timer_ctrl.sv
// Start/pause/clear countdown controller driving the NCO divisor and 6-bit counter.
// Optional build macro TIMER_AUTO_RELOAD_EN: DONE lasts one cycle, then reloads and reruns.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter logic [31:0] NUM_1HZ  = DEF_NUM_1HZ,
    parameter logic [31:0] NUM_FAST = DEF_NUM_FAST,
    parameter int          CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_pause,
    input  logic             i_clear,
    input  logic             i_fast,
    input  logic [CNT_W-1:0] i_preset,
    input  logic             i_clk_gen,
    output logic [31:0]      o_num,
    output logic             o_cnt_en,
    output logic             o_cnt_clr,
    output logic [CNT_W-1:0] o_remain,
    output logic             o_done,
    output logic [1:0]       o_state
);

    localparam logic [CNT_W-1:0] REM_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] REM_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic start_ev_s;
    logic pause_ev_s;
    logic clear_ev_s;
    logic tick_ev_s;

    state_e           state_d,  state_q;
    logic [CNT_W-1:0] remain_d, remain_q;
    logic             cnt_en_d, cnt_en_q;
    logic             cnt_clr_d, cnt_clr_q;
    logic             done_d,   done_q;
    logic [31:0]      num_d,    num_q;

    edge_det #(.SYNC(1'b0)) u_start (.clk(clk), .rst_n(rst_n), .i_in(i_start),   .o_pulse(start_ev_s));
    edge_det #(.SYNC(1'b0)) u_pause (.clk(clk), .rst_n(rst_n), .i_in(i_pause),   .o_pulse(pause_ev_s));
    edge_det #(.SYNC(1'b0)) u_clear (.clk(clk), .rst_n(rst_n), .i_in(i_clear),   .o_pulse(clear_ev_s));
    edge_det #(.SYNC(1'b1)) u_tick  (.clk(clk), .rst_n(rst_n), .i_in(i_clk_gen), .o_pulse(tick_ev_s));

    // Next-state, remaining count and pulse generation; priority clear > pause > start > tick.
    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        cnt_en_d  = 1'b0;
        cnt_clr_d = 1'b0;
        num_d     = i_fast ? NUM_FAST : NUM_1HZ;
        case (state_q)
            IDLE: begin
                remain_d = i_preset;
                if (start_ev_s && (i_preset != REM_ZERO)) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (clear_ev_s) begin
                    state_d   = IDLE;
                    remain_d  = i_preset;
                    cnt_clr_d = 1'b1;
                end else if (pause_ev_s) begin
                    state_d = PAUSE;
                end else if (tick_ev_s && (remain_q != REM_ZERO)) begin
                    remain_d = remain_q - REM_ONE;
                    cnt_en_d = 1'b1;
                    if (remain_q == REM_ONE) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            PAUSE: begin
                if (clear_ev_s) begin
                    state_d   = IDLE;
                    remain_d  = i_preset;
                    cnt_clr_d = 1'b1;
                end else if (pause_ev_s) begin
                    state_d = PAUSE;
                end else if (start_ev_s) begin
                    state_d = RUN;
                end else begin
                    state_d = PAUSE;
                end
            end
            DONE: begin
`ifdef TIMER_AUTO_RELOAD_EN
                if (clear_ev_s || (i_preset == REM_ZERO)) begin
                    state_d   = IDLE;
                    remain_d  = i_preset;
                    cnt_clr_d = 1'b1;
                end else begin
                    state_d  = RUN;
                    remain_d = i_preset;
                end
`else
                if (clear_ev_s || start_ev_s) begin
                    state_d   = IDLE;
                    remain_d  = i_preset;
                    cnt_clr_d = 1'b1;
                end else begin
                    state_d = DONE;
                end
`endif
            end
            default: begin
                state_d  = IDLE;
                remain_d = REM_ZERO;
            end
        endcase
        done_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            remain_q  <= REM_ZERO;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            done_q    <= 1'b0;
            num_q     <= NUM_1HZ;
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            cnt_en_q  <= cnt_en_d;
            cnt_clr_q <= cnt_clr_d;
            done_q    <= done_d;
            num_q     <= num_d;
        end
    end

    assign o_num     = num_q;
    assign o_cnt_en  = cnt_en_q;
    assign o_cnt_clr = cnt_clr_q;
    assign o_remain  = remain_q;
    assign o_done    = done_q;
    assign o_state   = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: cycle-indexed input history model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_timer_ctrl;
    import timer_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 i_start, i_pause, i_clear, i_fast, i_clk_gen;
    logic [DEF_CNT_W-1:0] i_preset;
    logic [31:0]          o_num;
    logic                 o_cnt_en, o_cnt_clr, o_done;
    logic [DEF_CNT_W-1:0] o_remain;
    logic [1:0]           o_state;

    int checks = 0;
    int errors = 0;

    timer_ctrl dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_pause(i_pause),
        .i_clear(i_clear), .i_fast(i_fast), .i_preset(i_preset),
        .i_clk_gen(i_clk_gen), .o_num(o_num), .o_cnt_en(o_cnt_en),
        .o_cnt_clr(o_cnt_clr), .o_remain(o_remain), .o_done(o_done),
        .o_state(o_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: inputs seen at each clk edge, indexed by edge number.
    bit h_st [0:4095];
    bit h_pa [0:4095];
    bit h_cl [0:4095];
    bit h_g  [0:4095];
    int n = 3;
    int m_state, m_remain, m_en, m_clr, m_done, m_num;
    bit m_valid = 1'b0;

    always @(posedge clk) begin : model
        int st, rem, en, clr, num;
        bit ev_s, ev_p, ev_c, tick;
        st  = m_state;
        rem = m_remain;
        en  = 0;
        clr = 0;
        if (!rst_n) begin
            st  = 0;
            rem = 0;
            num = 50_000_000;
        end else begin
            ev_s = h_st[n-1] && !h_st[n-2];
            ev_p = h_pa[n-1] && !h_pa[n-2];
            ev_c = h_cl[n-1] && !h_cl[n-2];
            tick = h_g[n-2]  && !h_g[n-3];
            num  = i_fast ? 5_000_000 : 50_000_000;
            if (st == 0) begin
                rem = int'(i_preset);
                if (ev_s && i_preset != 0) st = 1;
            end else if (ev_c) begin
                st = 0; rem = int'(i_preset); clr = 1;
            end else if (st == 3) begin
`ifdef TIMER_AUTO_RELOAD_EN
                rem = int'(i_preset);
                if (i_preset != 0) st = 1;
                else begin st = 0; clr = 1; end
`else
                if (ev_s) begin st = 0; rem = int'(i_preset); clr = 1; end
`endif
            end else if (ev_p) begin
                if (st == 1) st = 2;
            end else if (ev_s && st == 2) begin
                st = 1;
            end else if (tick && st == 1 && rem > 0) begin
                rem = rem - 1;
                en  = 1;
                if (rem == 0) st = 3;
            end
        end
        h_st[n] <= rst_n && i_start;
        h_pa[n] <= rst_n && i_pause;
        h_cl[n] <= rst_n && i_clear;
        h_g[n]  <= rst_n && i_clk_gen;
        n        <= n + 1;
        m_state  <= st;
        m_remain <= rem;
        m_en     <= en;
        m_clr    <= clr;
        m_done   <= (st == 3) ? 1 : 0;
        m_num    <= num;
        m_valid  <= 1'b1;
    end

    // Compare every DUT output with the model on the falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_state",   int'(o_state),   m_state);
            chk("m_remain",  int'(o_remain),  m_remain);
            chk("m_cnt_en",  int'(o_cnt_en),  m_en);
            chk("m_cnt_clr", int'(o_cnt_clr), m_clr);
            chk("m_done",    int'(o_done),    m_done);
            chk("m_num",     int'(o_num),     m_num);
        end
    end

    task automatic tk(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Raise i_clk_gen, return three edges later (tick visible on outputs).
    task automatic rise_tick();
        i_clk_gen = 1'b1;
        tk(2);
        chk("en_early", int'(o_cnt_en), 0);
        i_clk_gen = 1'b0;
        tk(1);
    endtask

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n = 1'b0; i_start = 1'b0; i_pause = 1'b0; i_clear = 1'b0;
        i_fast = 1'b0; i_clk_gen = 1'b0; i_preset = 6'd0;
        tk(3);
        rst_n = 1'b1;
        tk(1);
        chk("rst_state",  int'(o_state), 0);
        chk("rst_remain", int'(o_remain), 0);
        chk("rst_num",    int'(o_num), 50_000_000);
        chk("rst_pulses", int'({o_cnt_en, o_cnt_clr, o_done}), 0);

        // Countdown from 3.
        i_preset = 6'd3;
        tk(1);
        i_start = 1'b1;
        tk(2);
        chk("s2_run", int'(o_state), 1);
        chk("s2_rem", int'(o_remain), 3);
        i_start = 1'b0;
        tk(2);
        for (int k = 0; k < 3; k++) begin
            rise_tick();
            chk("s2_en", int'(o_cnt_en), 1);
            chk("s2_step", int'(o_remain), 2 - k);
            tk(1);
            chk("s2_en_1cyc", int'(o_cnt_en), 0);
`ifdef TIMER_AUTO_RELOAD_EN
            if (k == 2) begin
                chk("ar_state", int'(o_state), 1);
                chk("ar_rem", int'(o_remain), 3);
                chk("ar_done", int'(o_done), 0);
            end
`endif
            tk(2);
        end
`ifndef TIMER_AUTO_RELOAD_EN
        chk("s2_done_state", int'(o_state), 3);
        chk("s2_done", int'(o_done), 1);
`endif

        // Clear (DONE, or RUN with auto reload) with preset 5.
        i_preset = 6'd5;
        i_clear  = 1'b1;
        tk(2);
        chk("clr_state", int'(o_state), 0);
        chk("clr_pulse", int'(o_cnt_clr), 1);
        chk("clr_rem",   int'(o_remain), 5);
        tk(1);
        chk("clr_1cyc",  int'(o_cnt_clr), 0);
        i_clear = 1'b0;

        // Pause holds the count; ticks ignored.
        i_start = 1'b1;
        tk(2);
        i_start = 1'b0;
        tk(1);
        i_pause = 1'b1;
        tk(2);
        chk("pause_state", int'(o_state), 2);
        i_pause = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rise_tick();
            chk("pause_no_en", int'(o_cnt_en), 0);
            chk("pause_rem",   int'(o_remain), 5);
            tk(1);
        end
        i_start = 1'b1;
        tk(2);
        chk("resume_state", int'(o_state), 1);
        i_start = 1'b0;
        rise_tick();
        chk("resume_rem", int'(o_remain), 4);
        tk(2);

        // Tick and pause land on the same edge.
        i_clk_gen = 1'b1;
        tk(1);
        i_pause = 1'b1;
        tk(1);
        i_clk_gen = 1'b0;
        tk(1);
        chk("coin_state", int'(o_state), 2);
        chk("coin_rem",   int'(o_remain), 4);
        chk("coin_en",    int'(o_cnt_en), 0);
        i_pause = 1'b0;
        i_start = 1'b1;
        tk(2);
        chk("coin_resume", int'(o_state), 1);
        i_start = 1'b0;
        tk(1);

        // Reset mid-run: straight to IDLE, no clear pulse.
        rst_n = 1'b0;
        tk(1);
        chk("mrst_state", int'(o_state), 0);
        chk("mrst_clr",   int'(o_cnt_clr), 0);
        tk(2);
        rst_n = 1'b1;
        tk(1);

        // Clear in RUN.
        i_start = 1'b1;
        tk(2);
        chk("run2_state", int'(o_state), 1);
        i_start = 1'b0;
        tk(1);
        i_clear = 1'b1;
        tk(2);
        chk("clr_run_state", int'(o_state), 0);
        chk("clr_run_pulse", int'(o_cnt_clr), 1);
        chk("clr_run_rem",   int'(o_remain), 5);
        i_clear = 1'b0;
        tk(1);

        // Start with preset 0 stays IDLE.
        i_preset = 6'd0;
        tk(1);
        i_start = 1'b1;
        tk(3);
        chk("zero_state", int'(o_state), 0);
        chk("zero_rem",   int'(o_remain), 0);
        i_start = 1'b0;
        tk(1);

        // Fast rate select.
        i_fast = 1'b1;
        tk(1);
        chk("fast_on", int'(o_num), 5_000_000);
        i_fast = 1'b0;
        tk(1);
        chk("fast_off", int'(o_num), 50_000_000);
        tk(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Sequencing controller for the NCO + 6-bit counter datapath.
- Runs a start/pause/clear countdown FSM.
- Selects the NCO divisor word (`o_num`) for normal or fast rate.
- Converts the NCO generated clock into a single-cycle tick in the `clk` domain.
- Drives enable and clear pulses to the downstream 6-bit counter.
- Sits between the front-panel button inputs and the nco/cnt6 pair, one level below the top.

Parameters:
- NUM_1HZ, 32'd50_000_000, NCO divisor word for the 1 Hz tick.
- NUM_FAST, 32'd5_000_000, NCO divisor word for the 10 Hz fast mode.
- CNT_W, 6, width of the preset and remaining-count values.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- i_start  input  1  start/resume button level; rising edge acts.
- i_pause  input  1  pause button level; rising edge acts.
- i_clear  input  1  clear button level; rising edge acts.
- i_fast  input  1  level; 1 selects NUM_FAST.
- i_preset  input  CNT_W  countdown start value.
- i_clk_gen  input  1  NCO output, treated as asynchronous data.
- o_num  output  32  divisor word to the NCO.
- o_cnt_en  output  1  one-cycle count enable to the counter.
- o_cnt_clr  output  1  one-cycle clear to the counter.
- o_remain  output  CNT_W  remaining count.
- o_done  output  1  high while in DONE.
- o_state  output  2  FSM state encoding.

Behaviour:
- Reset: synchronous. When rst_n=0 at a clk edge, the following values apply:
  - state=IDLE
  - o_remain=0, o_cnt_en=0, o_cnt_clr=0, o_done=0
  - o_num=NUM_1HZ
  - edge-detect and sync flops cleared
- Reset mid-operation: aborts any state to IDLE on the next edge. No clear pulse is emitted.
- Button inputs:
  - Each is registered once, then a rising edge is detected: pulse = cur & ~prev.
  - One-cycle event, 2 cycles after the input rises.
  - A held button yields exactly one event.
- Tick generation:
  - i_clk_gen passes through a 2-flop synchronizer, then a rising-edge detector.
  - tick is one cycle wide, 3 clk cycles after the i_clk_gen rise.
- o_num:
  - Registered; o_num = i_fast ? NUM_FAST : NUM_1HZ.
  - Updates one cycle after i_fast changes, in any state.
- Event priority within a cycle: reset > clear > pause > start > tick.
- FSM encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3. Transitions:
  - IDLE:
    - o_remain loads i_preset every cycle.
    - start with i_preset!=0 → RUN.
    - start with i_preset==0 → stays IDLE; no pulses.
  - RUN:
    - clear → IDLE.
    - pause → PAUSE.
    - tick → o_remain decrements by 1 and o_cnt_en=1 that cycle.
    - tick with o_remain==1 → o_remain=0, then DONE.
    - start in RUN is ignored.
  - PAUSE:
    - o_remain is held; ticks are ignored and o_cnt_en stays 0.
    - start → RUN.
    - clear → IDLE.
  - DONE:
    - o_done=1; ticks are ignored.
    - clear or start → IDLE.
- o_cnt_clr: one-cycle pulse on every transition into IDLE (from RUN, PAUSE or DONE). It is registered, coincident with the state change.
- Simultaneous tick and pause in RUN: pause wins; no decrement, no o_cnt_en.
- No wrap-around: o_remain never decrements below 0.
- Outputs: all registered; o_state equals the state register.

Optional Feature:
- Macro: TIMER_AUTO_RELOAD_EN.
- With the macro:
  - DONE lasts exactly one cycle (o_done pulse).
  - It then reloads o_remain=i_preset and returns to RUN.
  - If i_preset==0 it goes to IDLE instead.
  - clear in that cycle takes priority → IDLE.
- Without the macro: DONE holds until clear or start, as above.

Decomposition:
- Package timer_pkg:
  - state typedef/localparams IDLE/RUN/PAUSE/DONE (2-bit)
  - NUM_1HZ and NUM_FAST defaults
  - CNT_W
- One sub-module, edge_det:
  - Optional 2-flop synchronizer plus rising-edge pulse.
  - Instantiated once per button and once for i_clk_gen.
- FSM and remain counter stay in timer_ctrl.

Test Plan:
1. Reset hold 3 cycles, then release → state=0, o_remain=0, o_num=50_000_000, all pulses 0.
2. i_preset=3, start pulse, three i_clk_gen rises → o_cnt_en pulses exactly 3×, 3 cycles after each rise. o_remain steps 3→2→1→0, state=DONE, o_done=1.
3. RUN at o_remain=5, then pause → next two ticks produce no o_cnt_en and o_remain stays 5. Start → RUN; the next tick gives o_remain=4.
4. i_clk_gen rise timed so tick and pause events coincide → no decrement, state=PAUSE.
5. Clear in RUN and in DONE → o_cnt_clr one-cycle pulse, state=IDLE, o_remain=i_preset. Start with i_preset=0 → stays IDLE.
6. Toggle i_fast → o_num=5_000_000 one cycle later, back to 50_000_000 one cycle after i_fast falls. Repeat scenario 2 under TIMER_AUTO_RELOAD_EN → single-cycle o_done, then o_remain=3 and state=RUN.
